inst_issue_queue: RTL

Parametrised circular instruction queue between the instruction fetcher and the decoder. Buffers fetched instructions with their PC and branch-prediction tags, and launches at most one instruction per cycle to the decoder. A launch happens only when the decoder, the reorder buffer and the target back-end structure can accept it; load/store instructions target the LS buffer, all others the reservation station. Adds configurable depth, a live occupancy count, sticky overflow detection and optional empty-queue bypass.

---
 rtl/iq_pkg.sv | 27 ++
 rtl/inst_issue_queue_if.sv | 58 +++++
 rtl/inst_issue_queue.sv | 125 ++++++++++++
 3 files changed

// File: rtl/iq_pkg.sv
// Shared definitions for the instruction issue queue: opcode constants,
// the stored entry layout and the load/store classification helper that
// the decoder also reuses.
package iq_pkg;

  // Payload widths carried inside each stored entry.
  localparam int IQ_INST_W = 32;
  localparam int IQ_ADDR_W = 32;

  // RISC-V major opcodes that route to the load/store buffer.
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  // One buffered instruction with its PC and prediction tags.
  typedef struct packed {
    logic [IQ_INST_W-1:0] inst;
    logic [IQ_ADDR_W-1:0] pc;
    logic                 pred_jump;
    logic [IQ_ADDR_W-1:0] pred_pc;
  } iq_entry_t;

  // True when the instruction targets the LS buffer rather than the RS.
  function automatic logic is_ls(input logic [IQ_INST_W-1:0] inst);
    return (inst[6:0] == OPCODE_LOAD) || (inst[6:0] == OPCODE_STORE);
  endfunction

endpackage

// File: rtl/inst_issue_queue_if.sv
// Fetch/decode-side bus of the instruction issue queue.
//
// Handshake: the fetcher may assert in_valid in a cycle only if iq_full was
// low in the previous cycle; an in_valid that meets a full queue is dropped
// and latched into overflow. On the decode side a transfer happens on every
// edge where the queue launches: out_valid is registered and is high for
// exactly the cycle after the launching edge, and the queue only launches
// when id_ready is high and the targeted back-end (rob plus rs or lsb) has
// room, so the decoder never has to stall a presented instruction.
// rdy low freezes the queue; flush discards everything buffered.
interface inst_issue_queue_if #(
  parameter int DEPTH  = 16,
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              rdy;
  logic              flush;
  logic              rob_full;
  logic              rs_full;
  logic              lsb_full;

  logic              in_valid;
  logic [INST_W-1:0] in_inst;
  logic [ADDR_W-1:0] in_pc;
  logic              in_pred_jump;
  logic [ADDR_W-1:0] in_pred_pc;
  logic              iq_full;
  logic [CW-1:0]     count;
  logic              overflow;

  logic              id_ready;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              out_pred_jump;
  logic [ADDR_W-1:0] out_pred_pc;

  // Environment side: fetcher, decoder and back-end status.
  modport master (
    output rdy, flush, rob_full, rs_full, lsb_full,
    output in_valid, in_inst, in_pc, in_pred_jump, in_pred_pc,
    output id_ready,
    input  iq_full, count, overflow,
    input  out_valid, out_inst, out_pc, out_pred_jump, out_pred_pc
  );

  // Queue side.
  modport slave (
    input  rdy, flush, rob_full, rs_full, lsb_full,
    input  in_valid, in_inst, in_pc, in_pred_jump, in_pred_pc,
    input  id_ready,
    output iq_full, count, overflow,
    output out_valid, out_inst, out_pc, out_pred_jump, out_pred_pc
  );

endinterface

// File: rtl/inst_issue_queue.sv
// Circular instruction queue between fetch and decode. Buffers instructions
// with PC and prediction tags and launches at most one per cycle when the
// decoder, ROB and the targeted back-end structure (LSB for loads/stores,
// RS otherwise) can all accept it.
// Optional feature macro: IQ_BYPASS_EN -- an instruction arriving at an empty
// queue that could launch right away goes straight to out_* on that edge.
module inst_issue_queue
  import iq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
) (
  input logic                clk,
  input logic                rst,
  inst_issue_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ALMOST = CW'(DEPTH - 1);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  iq_entry_t     mem [DEPTH];

  iq_entry_t     out_q;
  logic          out_valid_q;
  logic          overflow_q;

  iq_entry_t     head_e;
  iq_entry_t     in_e;
  logic          launch;
  logic          byp;
  logic          enq;
  logic          drop;

  // Launch / enqueue decisions for this cycle. launch never looks at
  // in_valid, which keeps in_valid out of the iq_full cone.
  always_comb begin
    head_e = mem[head];
    in_e   = '{inst:      IQ_INST_W'(bus.in_inst),
               pc:        IQ_ADDR_W'(bus.in_pc),
               pred_jump: bus.in_pred_jump,
               pred_pc:   IQ_ADDR_W'(bus.in_pred_pc)};

    launch = (cnt != '0) && bus.id_ready && !bus.rob_full &&
             (is_ls(head_e.inst) ? !bus.lsb_full : !bus.rs_full);

`ifdef IQ_BYPASS_EN
    byp = (cnt == '0) && bus.in_valid && bus.id_ready && !bus.rob_full &&
          (is_ls(in_e.inst) ? !bus.lsb_full : !bus.rs_full);
`else
    byp = 1'b0;
`endif

    enq  = bus.in_valid && (cnt != CNT_FULL) && !byp;
    drop = bus.in_valid && (cnt == CNT_FULL);
  end

  // Pointers, occupancy and output register; flush wins over launch/enqueue,
  // and rdy low freezes everything including flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        head        <= '0;
        tail        <= '0;
        cnt         <= '0;
        out_valid_q <= 1'b0;
      end else begin
        if (launch) begin
          out_q       <= head_e;
          out_valid_q <= 1'b1;
          head        <= head + PW'(1);
        end else if (byp) begin
          out_q       <= in_e;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
        if (enq) begin
          tail <= tail + PW'(1);
        end
        cnt <= cnt + CW'(enq) - CW'(launch);
      end
    end
  end

  // Sticky overflow: only reset clears it; a flush cycle discards in_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (bus.rdy && !bus.flush && drop) begin
      overflow_q <= 1'b1;
    end
  end

  // Entry storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (bus.rdy && !bus.flush && enq) begin
      mem[tail] <= in_e;
    end
  end

  // The fetcher sees "full" one cycle ahead: a queue one short of full is
  // reported full unless an instruction leaves this cycle.
  assign bus.iq_full = (cnt == CNT_FULL) || ((cnt == CNT_ALMOST) && !launch);

  assign bus.count         = cnt;
  assign bus.overflow      = overflow_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_inst      = INST_W'(out_q.inst);
  assign bus.out_pc        = ADDR_W'(out_q.pc);
  assign bus.out_pred_jump = out_q.pred_jump;
  assign bus.out_pred_pc   = ADDR_W'(out_q.pred_pc);

endmodule
